seven_seg_reader: RTL

Reads back the two active-low 7-segment digit buses (ones digit `d0`, tens digit `d1`) that drive the board display and recovers the 4-bit value 0–15 they show. It samples both buses every clock, waits until the pattern is stable, and checks that it is a legal display code. It then reports the value with a one-cycle strobe, or flags an error. It sits beside the display decoder as a self-check and debug monitor for the CPU's output path.

---
 rtl/seven_seg_reader.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : seven_seg_reader
// Purpose  : Monitors the two active-low 7-segment digit buses driving the
//            board display and recovers the value 0-15 they show. Both buses
//            are synchronized, must hold steady for STABLE_CYCLES samples,
//            and are then checked against the legal display codes.
// Ports    : clk        - clock, all state on rising edge
//            reset_n    - asynchronous active-low reset
//            d0, d1     - ones / tens digit segments (bit6 = g .. bit0 = a)
//            number     - last successfully decoded value
//            valid      - one-cycle strobe, number updated on this edge
//            err        - one-cycle strobe, stable pattern is illegal
//            blank      - last stable pattern had both digits dark
//            locked     - inputs stable and evaluated
//            err_count  - saturating count of err strobes
// Config   : SEVEN_SEG_READER_ERRCNT_EN - when defined, err_count is a real
//            saturating counter; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    output logic [3:0] number,
    output logic       valid,
    output logic       err,
    output logic       blank,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES - 1);
    // Count value (after this edge) at which the FSM moves into EVAL. With
    // the synchronizer and prev stages this places the strobe STABLE_CYCLES+2
    // edges after the first sampling edge. At least one matching compare is
    // always required, which matters only for STABLE_CYCLES == 2.
    localparam logic [CNT_W-1:0] c_eval_at =
        (STABLE_CYCLES > 2) ? CNT_W'(STABLE_CYCLES - 2) : CNT_W'(1);
    localparam logic [6:0] c_dark = 7'b1111111;
    localparam logic [6:0] c_one  = 7'b1111001;

    typedef enum logic [1:0] {
        ST_UNSTABLE = 2'd0,
        ST_EVAL     = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic [13:0]      r_sync1;
    logic [13:0]      r_sync2;   // synchronized word {d1,d0}
    logic [13:0]      r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_same;
    state_t           r_state;
    state_t           w_state_next;

    logic             w_ones_ok;
    logic [3:0]       w_ones_val;
    logic             w_tens_dark;
    logic             w_tens_one;
    logic             w_all_dark;
    logic             w_legal;
    logic [3:0]       w_value;
    logic             w_fire;
    logic             w_err_hit;

    // ---------------- synchronizer, history and stability counter -----------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_prev  <= '1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {d1, d0};
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_same = (r_sync2 == r_prev);

    always_comb begin
        w_cnt_next = '0;
        if (w_same) begin
            w_cnt_next = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
        end
    end

    // ---------------- FSM ----------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_UNSTABLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (!w_same) begin
            w_state_next = ST_UNSTABLE;
        end else begin
            case (r_state)
                ST_UNSTABLE: if (w_cnt_next == c_eval_at) w_state_next = ST_EVAL;
                ST_EVAL:     w_state_next = ST_LOCKED;
                ST_LOCKED:   w_state_next = ST_LOCKED;
                default:     w_state_next = ST_UNSTABLE;
            endcase
        end
    end

    assign locked = (r_state == ST_LOCKED);

    // ---------------- pattern decode ----------------------------------------
    always_comb begin
        w_ones_ok  = 1'b1;
        w_ones_val = 4'd0;
        case (r_sync2[6:0])
            7'b1000000: w_ones_val = 4'd0;
            7'b1111001: w_ones_val = 4'd1;
            7'b0100100: w_ones_val = 4'd2;
            7'b0110000: w_ones_val = 4'd3;
            7'b0011001: w_ones_val = 4'd4;
            7'b0010010: w_ones_val = 4'd5;
            7'b0000010: w_ones_val = 4'd6;
            7'b1111000: w_ones_val = 4'd7;
            7'b0000000: w_ones_val = 4'd8;
            7'b0011000: w_ones_val = 4'd9;
            default:    w_ones_ok  = 1'b0;
        endcase
    end

    assign w_tens_dark = (r_sync2[13:7] == c_dark);
    assign w_tens_one  = (r_sync2[13:7] == c_one);
    assign w_all_dark  = w_tens_dark && (r_sync2[6:0] == c_dark);
    assign w_legal     = w_ones_ok && (w_tens_dark || (w_tens_one && (w_ones_val <= 4'd5)));
    assign w_value     = w_tens_one ? (w_ones_val + 4'd10) : w_ones_val;

    // Evaluation happens on the edge leaving EVAL; a change seen in that
    // cycle sends the FSM back to UNSTABLE and suppresses the result.
    assign w_fire    = (r_state == ST_EVAL) && w_same;
    assign w_err_hit = w_fire && !w_legal && !w_all_dark;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            number <= 4'd0;
            valid  <= 1'b0;
            err    <= 1'b0;
            blank  <= 1'b1;
        end else begin
            valid <= w_fire && w_legal;
            err   <= w_err_hit;
            if (w_fire && w_legal) begin
                number <= w_value;
                blank  <= 1'b0;
            end else if (w_fire && w_all_dark) begin
                blank  <= 1'b1;
            end
        end
    end

    // ---------------- optional error counter --------------------------------
`ifdef SEVEN_SEG_READER_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count <= 8'd0;
        end else if (w_err_hit && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire
